// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared external ALU.
// One operation in flight at a time: accept in IDLE, sample the ALU in EXEC, hold the response in RESP.
module alu_arbiter (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_req0_valid,
   input  logic [3:0] i_req0_a,
   input  logic [3:0] i_req0_b,
   input  logic [2:0] i_req0_sel,
   output logic       o_req0_ready,
   input  logic       i_req1_valid,
   input  logic [3:0] i_req1_a,
   input  logic [3:0] i_req1_b,
   input  logic [2:0] i_req1_sel,
   output logic       o_req1_ready,
   output logic [3:0] o_alu_a,
   output logic [3:0] o_alu_b,
   output logic [2:0] o_alu_sel,
   input  logic [3:0] i_alu_res,
   input  logic       i_alu_carry,
   input  logic       i_alu_ovf,
   input  logic       i_alu_zero,
   input  logic       i_alu_sign,
   output logic       o_rsp_valid,
   input  logic       i_rsp_ready,
   output logic       o_rsp_id,
   output logic [3:0] o_rsp_result,
   output logic [3:0] o_rsp_flags,
   output logic [7:0] o_done_cnt,
   output logic [1:0] o_dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
   // Ready never depends on anything but state, valids and the last grant.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t r_state;
   logic   r_last_gnt;
   logic   r_gnt_id;
   logic   w_idle;
   logic   w_gnt1;
   logic   w_accept;

   // Requester 1 wins when it is alone, or when both ask and 0 was served last.
   assign w_idle       = (r_state == ST_IDLE);
   assign w_gnt1       = i_req1_valid & (~i_req0_valid | ~r_last_gnt);
   assign w_accept     = w_idle & (i_req0_valid | i_req1_valid);
   assign o_req0_ready = w_idle & i_req0_valid & ~w_gnt1;
   assign o_req1_ready = w_idle & w_gnt1;
   assign o_rsp_valid  = (r_state == ST_RESP);
   assign o_dbg_state  = r_state;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state      <= ST_IDLE;
         r_last_gnt   <= 1'b1;
         r_gnt_id     <= 1'b0;
         o_alu_a      <= 4'd0;
         o_alu_b      <= 4'd0;
         o_alu_sel    <= 3'd0;
         o_rsp_id     <= 1'b0;
         o_rsp_result <= 4'd0;
         o_rsp_flags  <= 4'd0;
         o_done_cnt   <= 8'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  o_alu_a    <= w_gnt1 ? i_req1_a   : i_req0_a;
                  o_alu_b    <= w_gnt1 ? i_req1_b   : i_req0_b;
                  o_alu_sel  <= w_gnt1 ? i_req1_sel : i_req0_sel;
                  r_gnt_id   <= w_gnt1;
                  r_last_gnt <= w_gnt1;
                  r_state    <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               o_rsp_result <= i_alu_res;
               o_rsp_flags  <= {i_alu_carry, i_alu_ovf, i_alu_zero, i_alu_sign};
               o_rsp_id     <= r_gnt_id;
               r_state      <= ST_RESP;
            end
            ST_RESP: begin
               if (i_rsp_ready) begin
                  o_done_cnt <= o_done_cnt + 8'd1;
                  r_state    <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU and transaction-level model, per-cycle compare,
// directed cases with literal expectations, then randomized traffic with occasional resets.
module tb_alu_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req0_valid = 1'b0, req1_valid = 1'b0;
   logic [3:0] req0_a = 4'd0, req0_b = 4'd0, req1_a = 4'd0, req1_b = 4'd0;
   logic [2:0] req0_sel = 3'd0, req1_sel = 3'd0;
   logic       rsp_ready = 1'b0;
   logic       req0_ready, req1_ready;
   logic [3:0] alu_a, alu_b, alu_res;
   logic [2:0] alu_sel;
   logic       alu_carry, alu_ovf, alu_zero, alu_sign;
   logic       rsp_valid, rsp_id;
   logic [3:0] rsp_result, rsp_flags;
   logic [7:0] done_cnt;
   logic [1:0] dbg_state;

   int checks = 0;
   int errors = 0;

   alu_arbiter dut (
      .i_clk(clk), .i_rst(rst),
      .i_req0_valid(req0_valid), .i_req0_a(req0_a), .i_req0_b(req0_b), .i_req0_sel(req0_sel),
      .o_req0_ready(req0_ready),
      .i_req1_valid(req1_valid), .i_req1_a(req1_a), .i_req1_b(req1_b), .i_req1_sel(req1_sel),
      .o_req1_ready(req1_ready),
      .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_sel(alu_sel),
      .i_alu_res(alu_res), .i_alu_carry(alu_carry), .i_alu_ovf(alu_ovf),
      .i_alu_zero(alu_zero), .i_alu_sign(alu_sign),
      .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_id(rsp_id),
      .o_rsp_result(rsp_result), .o_rsp_flags(rsp_flags),
      .o_done_cnt(done_cnt), .o_dbg_state(dbg_state)
   );

   // ---------------- clock ----------------
   initial forever #5 clk = ~clk;

   // ALU behaviour: returns {result[3:0], carry, ovf, zero, sign}
   function automatic logic [7:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel);
      int sa, sb, sr;
      logic [3:0] r;
      logic c, v;
      sa = (a >= 8) ? int'(a) - 16 : int'(a);
      sb = (b >= 8) ? int'(b) - 16 : int'(b);
      c = 1'b0; v = 1'b0; sr = 0;
      case (sel)
         3'd0: begin r = 4'((int'(a) + int'(b)) % 16); c = (int'(a) + int'(b)) > 15; sr = sa + sb; v = (sr > 7) || (sr < -8); end
         3'd1: begin r = 4'((int'(a) - int'(b) + 16) % 16); c = (a < b); sr = sa - sb; v = (sr > 7) || (sr < -8); end
         3'd2: r = a & b;
         3'd3: r = a | b;
         3'd4: r = a ^ b;
         3'd5: r = ~(a & b);
         3'd6: r = ~(a ^ b);
         default: r = ~(a | b);
      endcase
      return {r, c, v, (r == 4'd0), r[3]};
   endfunction

   assign {alu_res, alu_carry, alu_ovf, alu_zero, alu_sign} = alu_fn(alu_a, alu_b, alu_sel);

   // ---------------- reference model ----------------
   logic [8:0] exp_q[$];           // {id, result, flags} of the operation in flight
   int         cyc = 0;
   int         m_acc = 0;          // cycle index at which the in-flight op was accepted
   logic       m_last;
   logic [7:0] m_done;
   logic [3:0] m_alu_a, m_alu_b;
   logic [2:0] m_alu_sel;

   function automatic int pick(input logic v0, input logic v1, input logic last);
      if (v0 && v1) return (last == 1'b1) ? 0 : 1;
      return v1 ? 1 : 0;
   endfunction

   task model_reset();
      exp_q.delete();
      m_last = 1'b1; m_done = 8'd0;
      m_alu_a = 4'd0; m_alu_b = 4'd0; m_alu_sel = 3'd0;
   endtask

   task model_step();
      int g;
      logic [7:0] r;
      if (exp_q.size() != 0) begin
         if (cyc >= m_acc + 1 && rsp_ready) begin
            void'(exp_q.pop_front());
            m_done = m_done + 8'd1;
         end
      end else if (req0_valid || req1_valid) begin
         g = pick(req0_valid, req1_valid, m_last);
         m_alu_a   = (g == 1) ? req1_a   : req0_a;
         m_alu_b   = (g == 1) ? req1_b   : req0_b;
         m_alu_sel = (g == 1) ? req1_sel : req0_sel;
         r = alu_fn(m_alu_a, m_alu_b, m_alu_sel);
         exp_q.push_back({1'(g), r});
         m_last = 1'(g);
         m_acc = cyc + 1;
      end
      cyc++;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or posedge rst);
         if (rst) model_reset();
         else model_step();
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      logic exp_v;
      int g;
      if (rst) begin
         chk("rst_rsp_valid", rsp_valid, 0);
         chk("rst_done_cnt", done_cnt, 0);
      end else begin
         exp_v = (exp_q.size() != 0) && (cyc >= m_acc + 1);
         g = pick(req0_valid, req1_valid, m_last);
         chk("ready0", req0_ready, (exp_q.size() == 0) && req0_valid && g == 0);
         chk("ready1", req1_ready, (exp_q.size() == 0) && req1_valid && g == 1);
         chk("ready_both", req0_ready & req1_ready, 0);
         chk("rsp_valid", rsp_valid, exp_v);
         chk("done_cnt", done_cnt, m_done);
         chk("alu_opnds", {alu_a, alu_b, alu_sel}, {m_alu_a, m_alu_b, m_alu_sel});
         if (exp_v) chk("rsp_payload", {rsp_id, rsp_result, rsp_flags}, exp_q[0]);
      end
   end

   // ---------------- driver tasks ----------------
   task tick();
      @(posedge clk); #1;
   endtask

   task do_reset();
      rst = 1'b1; tick(); tick(); rst = 1'b0;
   endtask

   task wait_valid(output int n);
      n = 0;
      while (!rsp_valid && n < 10) begin tick(); n++; end
   endtask

   task run_op(input int id, input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel,
               input logic [3:0] e_res, input logic [3:0] e_flags, input logic [7:0] e_done);
      int n;
      rsp_ready = 1'b1;
      if (id == 0) begin req0_valid = 1; req0_a = a; req0_b = b; req0_sel = sel; end
      else begin req1_valid = 1; req1_a = a; req1_b = b; req1_sel = sel; end
      #1;
      chk("op_ready", (id == 0) ? req0_ready : req1_ready, 1);
      tick();
      req0_valid = 0; req1_valid = 0;
      req0_a = ~a; req1_a = ~a;   // later input changes must not disturb the op
      wait_valid(n);
      chk("op_latency", n, 1);
      chk("op_result", rsp_result, e_res);
      chk("op_flags", rsp_flags, e_flags);
      chk("op_id", rsp_id, id);
      tick();
      chk("op_done", done_cnt, e_done);
      chk("op_rsp_drop", rsp_valid, 0);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #400000;
      $display("FAIL watchdog actual=timeout required=finish");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int gq[$];
      int n;
      repeat (3) tick();
      chk("reset_alu", {alu_a, alu_b, alu_sel}, 0);
      chk("reset_rsp", {rsp_valid, rsp_id, rsp_result, rsp_flags}, 0);
      chk("reset_cnt", done_cnt, 0);
      rst = 1'b0;
      tick();

      run_op(0, 4'b0111, 4'b0001, 3'b000, 4'b1000, 4'b0101, 8'd1);
      run_op(1, 4'b0011, 4'b0011, 3'b001, 4'b0000, 4'b0010, 8'd2);
      run_op(0, 4'b0010, 4'b0011, 3'b001, 4'b1111, 4'b1001, 8'd3);

      // both requesters asking continuously after reset
      do_reset();
      req0_valid = 1; req1_valid = 1; rsp_ready = 1;
      for (int i = 0; i < 12; i++) begin
         #1;
         if (req0_ready) gq.push_back(0);
         if (req1_ready) gq.push_back(1);
         tick();
      end
      req0_valid = 0; req1_valid = 0;
      chk("rr_count", gq.size(), 4);
      if (gq.size() == 4) begin
         chk("rr_g0", gq[0], 0); chk("rr_g1", gq[1], 1);
         chk("rr_g2", gq[2], 0); chk("rr_g3", gq[3], 1);
      end
      repeat (3) tick();

      // response backpressure
      rsp_ready = 0;
      req0_valid = 1; req0_a = 4'b0101; req0_b = 4'b1010; req0_sel = 3'b111;
      tick();
      req0_valid = 0;
      wait_valid(n);
      req1_valid = 1; req1_a = 4'd9; req1_b = 4'd9; req1_sel = 3'd0;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp_valid", rsp_valid, 1);
         chk("bp_payload", {rsp_id, rsp_result, rsp_flags}, {1'b0, 4'b0000, 4'b0010});
         chk("bp_ready", {req0_ready, req1_ready}, 0);
         tick();
      end
      rsp_ready = 1; req1_valid = 0;
      tick();
      chk("bp_done", done_cnt, 5);
      chk("bp_release", rsp_valid, 0);
      repeat (2) tick();

      // reset while a response is held
      rsp_ready = 0;
      req1_valid = 1; req1_a = 4'd3; req1_b = 4'd4; req1_sel = 3'd0;
      tick();
      req1_valid = 0;
      wait_valid(n);
      chk("rr_pre_valid", rsp_valid, 1);
      #3 rst = 1;
      #1;
      chk("async_rsp_valid", rsp_valid, 0);
      chk("async_done", done_cnt, 0);
      chk("async_alu_a", alu_a, 0);
      rsp_ready = 1;
      tick(); tick(); rst = 0;
      repeat (3) begin tick(); chk("abort_no_rsp", rsp_valid, 0); end
      chk("abort_done", done_cnt, 0);

      // 256 completions wrap the counter
      do_reset();
      rsp_ready = 1; req0_valid = 1; req0_a = 4'd1; req0_b = 4'd2; req0_sel = 3'd4;
      repeat (767) tick();
      chk("wrap_255", done_cnt, 255);
      tick();
      chk("wrap_0", done_cnt, 0);
      req0_valid = 0;
      repeat (3) tick();

      // randomized traffic
      for (int i = 0; i < 2000; i++) begin
         req0_valid = 1'($urandom_range(0, 1));
         req1_valid = 1'($urandom_range(0, 1));
         req0_a = 4'($urandom_range(0, 15)); req0_b = 4'($urandom_range(0, 15));
         req1_a = 4'($urandom_range(0, 15)); req1_b = 4'($urandom_range(0, 15));
         req0_sel = 3'($urandom_range(0, 7)); req1_sel = 3'($urandom_range(0, 7));
         rsp_ready = ($urandom_range(0, 3) != 0);
         rst = ($urandom_range(0, 199) == 0);
         tick();
      end
      rst = 0; req0_valid = 0; req1_valid = 0; rsp_ready = 1;
      repeat (5) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
